vga_timing_gen: RTL and testbench

Parametrised VGA/XGA raster timing generator, successor to the fixed-mode 1024x768 generator. It produces sync, blanking and pixel-coordinate signals for any mode given by the four horizontal and four vertical timing parameters, with configurable sync polarity. All outputs are registered and cycle-aligned to the pixel they describe, and a frame counter is provided. It sits between the pixel-strobe generator and the framebuffer/filter read path.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_axis_counter.sv | 55 +++++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing-mode definitions for the VGA/XGA raster generator.
// Modes are listed as active/front porch/sync/back porch per axis.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_mode_t;

    localparam vga_mode_t XGA_1024x768_60 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
    };

    localparam vga_mode_t XGA_1024x768_75 = '{
        h_active: 1024, h_fp: 16, h_sync: 96, h_bp: 176,
        v_active: 768,  v_fp: 1,  v_sync: 3,  v_bp: 28
    };

    localparam vga_mode_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    function automatic int unsigned total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decodes of its next value,
// so the parent can register outputs that line up with the counter itself.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = 1024,
    parameter int unsigned FP     = 24,
    parameter int unsigned SYNC   = 136,
    parameter int unsigned BP     = 160,
    parameter logic        POL    = 1'b0,
    parameter int unsigned W      = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic         wrap,
    output logic [W-1:0] nxt,
    output logic         vis_nxt,
    output logic         sync_nxt,
    output logic         first_nxt,
    output logic         last_nxt
);

    localparam int unsigned TOTAL      = total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    logic [W-1:0] cnt;
    logic         at_last;
    logic [31:0]  nxt_wide;

    always_comb begin
        at_last  = (cnt == W'(TOTAL - 1));
        wrap     = en && at_last;
        nxt      = cnt;
        if (en) begin
            nxt = at_last ? '0 : cnt + W'(1);
        end
        // Compare at 32 bits: SYNC_END may equal TOTAL, which need not fit in W.
        nxt_wide  = 32'(nxt);
        vis_nxt   = (nxt_wide < ACTIVE);
        sync_nxt  = ((nxt_wide >= SYNC_START) && (nxt_wide < SYNC_END)) ? POL : ~POL;
        first_nxt = (nxt == '0);
        last_nxt  = (nxt == W'(TOTAL - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, strobes and visible
// coordinates, all registered from next-pixel decodes so they track h/v exactly.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned XW       = 11,
    parameter int unsigned YW       = 10,
    parameter int unsigned FCW      = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_stb,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           blanking,
    output logic           line_start,
    output logic           frame_start,
    output logic           animate,
    output logic           screenend,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic [FCW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
        $error("vga_timing_gen: timing parameters must be non-zero");
    end
    if (64'(H_TOTAL - 1) >= (64'd1 << XW) || 64'(V_TOTAL - 1) >= (64'd1 << YW)) begin : g_width_param
        $error("vga_timing_gen: XW/YW too narrow for H_TOTAL-1/V_TOTAL-1");
    end

    logic          h_wrap, h_vis_n, h_sync_n, h_first_n, h_last_n;
    logic          v_wrap, v_vis_n, v_sync_n, v_first_n, v_last_n;
    logic [XW-1:0] h_nxt;
    logic [YW-1:0] v_nxt;
    logic          active_nxt;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (XW)
    ) u_h (
        .clk       (clk),
        .reset     (reset),
        .en        (pix_stb),
        .wrap      (h_wrap),
        .nxt       (h_nxt),
        .vis_nxt   (h_vis_n),
        .sync_nxt  (h_sync_n),
        .first_nxt (h_first_n),
        .last_nxt  (h_last_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (YW)
    ) u_v (
        .clk       (clk),
        .reset     (reset),
        .en        (h_wrap),
        .wrap      (v_wrap),
        .nxt       (v_nxt),
        .vis_nxt   (v_vis_n),
        .sync_nxt  (v_sync_n),
        .first_nxt (v_first_n),
        .last_nxt  (v_last_n)
    );

    always_comb begin
        active_nxt = h_vis_n && v_vis_n;
    end

    // Next-state values equal current ones without pix_stb, so outputs hold naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b1;
            blanking    <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            animate     <= 1'b0;
            screenend   <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_cnt   <= '0;
        end else begin
            hsync       <= h_sync_n;
            vsync       <= v_sync_n;
            active      <= active_nxt;
            blanking    <= ~active_nxt;
            line_start  <= h_first_n;
            frame_start <= h_first_n && v_first_n;
            animate     <= h_last_n && (v_nxt == YW'(V_ACTIVE - 1));
            screenend   <= h_last_n && v_last_n;
            if (active_nxt) begin
                x <= h_nxt;
            end
            y <= v_vis_n ? v_nxt : YW'(V_ACTIVE - 1);
            if (v_wrap) begin
                frame_cnt <= frame_cnt + FCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a small 16x8 raster with a
// raster-position reference model.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 4;
    localparam int VA = 4, VF = 1, VS = 1, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = 4, YW = 3, FCW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pix_stb = 1'b0;
    logic           hsync, vsync, active, blanking;
    logic           line_start, frame_start, animate, screenend;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [FCW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    // Reference raster position
    int mh = 0, mv = 0, mf = 0, mx = 0;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (1'b0), .VS_POL (1'b1),
        .XW (XW), .YW (YW), .FCW (FCW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_stb     (pix_stb),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .blanking    (blanking),
        .line_start  (line_start),
        .frame_start (frame_start),
        .animate     (animate),
        .screenend   (screenend),
        .x           (x),
        .y           (y),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] exp_vec();
        logic act, hs, vs;
        act = (mh < HA) && (mv < VA);
        hs  = !((mh >= HA + HF) && (mh < HA + HF + HS));
        vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
        return {hs, vs, act, !act, mh == 0, (mh == 0) && (mv == 0),
                (mh == HT - 1) && (mv == VA - 1), (mh == HT - 1) && (mv == VT - 1),
                4'(mx), 3'((mv < VA) ? mv : VA - 1), 4'(mf)};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {hsync, vsync, active, blanking, line_start, frame_start,
                animate, screenend, x, y, frame_cnt};
    endfunction

    // One clk with the given inputs; the model follows the pixel-advance rules.
    task automatic advance(input logic stb, input logic rst);
        pix_stb = stb;
        reset   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            mh = 0; mv = 0; mf = 0; mx = 0;
        end else if (stb) begin
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = mv + 1;
                if (mv == VT) begin
                    mv = 0;
                    mf = (mf + 1) % (1 << FCW);
                end
            end
            if (mh < HA && mv < VA) mx = mh;
        end
    endtask

    task automatic test_reset();
        advance(1'b1, 1'b1);
        advance(1'b0, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({frame_start, line_start, active, hsync, vsync} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 11110",
                     {frame_start, line_start, active, hsync, vsync});
        end
    endtask

    task automatic test_first_frame();
        int seen_end = 0;
        advance(1'b0, 1'b0);
        for (int i = 0; i < HT * VT; i++) begin
            advance(1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL frame_pixel(%0d,%0d): got %h expected %h", mh, mv, obs_vec(), exp_vec());
            end
            if (screenend === 1'b1 && mh == HT - 1 && mv == VT - 1) seen_end++;
        end
        checks++;
        if (seen_end != 1) begin
            failures++;
            $display("FAIL screenend_seen: got %0d expected 1", seen_end);
        end
        checks++;
        if ({frame_start, frame_cnt} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL frame_restart: got fs=%b fc=%0d expected fs=1 fc=1", frame_start, frame_cnt);
        end
    endtask

    task automatic test_slow_strobe();
        for (int i = 0; i < 70; i++) begin
            for (int k = 0; k < 3; k++) begin
                advance(k == 0, 1'b0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL slow_strobe(%0d,%0d,clk%0d): got %h expected %h",
                             mh, mv, k, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            advance(1'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_strobe(%0d,%0d): got %h expected %h", mh, mv, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        while (!(mh == 9 && mv == 2) && budget < 2 * HT * VT) begin
            advance(1'b1, 1'b0);
            budget++;
        end
        checks++;
        if (!(mh == 9 && mv == 2)) begin
            failures++;
            $display("FAIL reach_9_2: got (%0d,%0d) expected (9,2)", mh, mv);
        end
        advance(1'b1, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        if ({frame_cnt, x, y} !== '0) begin
            failures++;
            $display("FAIL reset_mid_counts: got fc=%0d x=%0d y=%0d expected 0 0 0", frame_cnt, x, y);
        end
    endtask

    task automatic test_frame_wrap();
        int saw_wrap = 0;
        logic [FCW-1:0] prev;
        advance(1'b0, 1'b0);
        for (int i = 0; i < ((1 << FCW) + 1) * HT * VT; i++) begin
            prev = frame_cnt;
            advance(1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_pixel(%0d,%0d): got %h expected %h", mh, mv, obs_vec(), exp_vec());
            end
            if (prev == 4'd15 && frame_cnt == 4'd0) saw_wrap++;
        end
        checks++;
        if (saw_wrap != 1 || frame_cnt !== 4'd1) begin
            failures++;
            $display("FAIL frame_cnt_wrap: got wraps=%0d fc=%0d expected wraps=1 fc=1", saw_wrap, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_slow_strobe();
        test_random();
        test_reset_mid();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
